// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  localparam int          INSTR_W  = 32;
  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// PC owner and IF/ID register: drives the instruction ROM address, captures the
// returned word, follows downstream redirects and halts after a run of zero words.
//
// state | meaning
// BOOT  | single post-reset cycle, nothing captured
// RUN   | normal fetch, one capture per cycle unless decode stalls
// HALT  | fetch past end of program; waits for redirect or resume
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter int                HALT_ZERO_RUN = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               resume,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc4,
  output logic               halted
);

  localparam int ZW = (HALT_ZERO_RUN > 0) ? $clog2(HALT_ZERO_RUN + 1) : 1;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [ZW-1:0]      zero_cnt_q, zero_cnt_d;

  logic               advance;
  logic [ADDR_W-1:0]  target_aligned;
  logic [ZW-1:0]      zero_cnt_inc;

  assign advance        = !if_valid_q || id_ready;
  assign target_aligned = redirect_target & ~ADDR_W'(3);
  assign zero_cnt_inc   = (zero_cnt_q == {ZW{1'b1}}) ? zero_cnt_q : zero_cnt_q + ZW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      zero_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    zero_cnt_d = zero_cnt_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (redirect) begin
          pc_d       = target_aligned;
          if_valid_d = 1'b0;
          zero_cnt_d = '0;
        end else if (advance) begin
          if_instr_d = imem_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(4);
          zero_cnt_d = (imem_data == NOP_WORD) ? zero_cnt_inc : '0;
          // HALT_ZERO_RUN of 0 disables the end-of-program detector entirely
          if ((HALT_ZERO_RUN != 0) && (zero_cnt_d >= ZW'(HALT_ZERO_RUN)))
            state_d = HALT;
        end
      end

      HALT: begin
        if (id_ready)
          if_valid_d = 1'b0;
        if (redirect) begin
          pc_d       = target_aligned;
          if_valid_d = 1'b0;
          zero_cnt_d = '0;
          state_d    = RUN;
        end else if (resume) begin
          zero_cnt_d = '0;
          state_d    = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc_q + ADDR_W'(4);
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for the main fetch flow plus
// hand sequences for redirect/halt/resume/reset corner cases.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        resume;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        res;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ea;
    logic        eh;
  } vec_t;

  vec_t vecs[$];

  fetch_sequencer #(
    .ADDR_W(32), .RESET_PC(32'h0), .HALT_ZERO_RUN(4)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_ready(id_ready), .redirect(redirect), .redirect_target(redirect_target),
    .resume(resume), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc4(if_pc4), .halted(halted)
  );

  always #5 clk = ~clk;

  // Program ROM: two standard words, eight nonzero filler words up to 0x24, zeros beyond.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0)                       return 32'h2011_0003;
    if (a == 32'h4)                       return 32'h2210_0001;
    if (a <= 32'h24 && a[1:0] == 2'b00)   return 32'h0010_0000 + a;
    return 32'h0;
  endfunction

  always_comb imem_data = rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ei,
                         input logic [31:0] ep, input logic [31:0] ea, input logic eh);
    chk({tag, ".if_valid"},  32'(if_valid), 32'(ev));
    chk({tag, ".imem_addr"}, imem_addr, ea);
    chk({tag, ".halted"},    32'(halted), 32'(eh));
    chk({tag, ".if_instr"},  if_instr, ei);
    chk({tag, ".if_pc"},     if_pc, ep);
    chk({tag, ".if_pc4"},    if_pc4, ep + 32'd4);
  endtask

  task automatic drive(input logic rdy, input logic rd, input logic [31:0] tgt, input logic rs);
    id_ready        = rdy;
    redirect        = rd;
    redirect_target = tgt;
    resume          = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rdy, input logic rd, input logic [31:0] tgt, input logic rs,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] ea, input logic eh);
    vec_t v;
    v.rdy = rdy; v.redir = rd; v.tgt = tgt; v.res = rs;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.eh = eh;
    vecs.push_back(v);
  endtask

  initial begin
    // BOOT edge, then first capture
    add(1, 0, 0, 0,  0, 32'h0,     32'h0, 32'h0, 0);
    add(1, 0, 0, 0,  1, rom(0),    32'h0, 32'h4, 0);
    add(1, 0, 0, 0,  1, rom(4),    32'h4, 32'h8, 0);
    // stall with if_pc=4
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0,  1, rom(4), 32'h4, 32'h8, 0);
    add(1, 0, 0, 0,  1, rom(8),    32'h8, 32'hC, 0);
    for (int a = 'hC; a <= 'h20; a += 4)
      add(1, 0, 0, 0,  1, rom(32'(a)), 32'(a), 32'(a + 4), 0);
    // redirect to 4 while pc=0x24: flush, if_instr/if_pc hold
    add(1, 1, 32'h4, 0,  0, rom(32'h20), 32'h20, 32'h4, 0);
    for (int a = 4; a <= 'h24; a += 4)
      add(1, 0, 0, 0,  1, rom(32'(a)), 32'(a), 32'(a + 4), 0);
    // zero run 0x28..0x34
    for (int a = 'h28; a <= 'h30; a += 4)
      add(1, 0, 0, 0,  1, 32'h0, 32'(a), 32'(a + 4), 0);
    add(1, 0, 0, 0,  1, 32'h0, 32'h34, 32'h38, 1);
    add(1, 0, 0, 0,  0, 32'h0, 32'h34, 32'h38, 1);
    add(1, 0, 0, 0,  0, 32'h0, 32'h34, 32'h38, 1);
    add(1, 1, 32'h0, 0,  0, 32'h0, 32'h34, 32'h0, 0);
    add(1, 0, 0, 0,  1, rom(0), 32'h0, 32'h4, 0);
    // resume in RUN is ignored
    add(1, 0, 0, 1,  1, rom(4), 32'h4, 32'h8, 0);

    drive(1, 0, 0, 0);
    reset = 1'b1;
    #12;
    reset = 1'b0;
    #1;
    chk_all("boot", 0, 32'h0, 32'h0, 32'h0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rdy, vecs[k].redir, vecs[k].tgt, vecs[k].res);
      step();
      chk_all($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ei, vecs[k].ep, vecs[k].ea, vecs[k].eh);
    end

    // unaligned target is forced to word alignment
    drive(1, 1, 32'h7, 0); step();
    chk("align.imem_addr", imem_addr, 32'h4);
    chk("align.if_valid", 32'(if_valid), 32'h0);

    // redirect on the edge of the 4th zero capture wins; no HALT
    drive(1, 1, 32'h28, 0); step();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pre4.halted%0d", i), 32'(halted), 32'h0);
    end
    chk("pre4.imem_addr", imem_addr, 32'h34);
    drive(1, 1, 32'h0, 0); step();
    chk_all("race", 0, 32'h0, 32'h30, 32'h0, 0);
    drive(1, 0, 0, 0); step();
    chk_all("race.after", 1, rom(0), 32'h0, 32'h4, 0);

    // halt, pending if_valid held under stall, then resume clears zero count
    drive(1, 1, 32'h28, 0); step();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    chk_all("halt2", 1, 32'h0, 32'h34, 32'h38, 1);
    drive(0, 0, 0, 0); step();
    chk_all("halt2.stall", 1, 32'h0, 32'h34, 32'h38, 1);
    drive(1, 0, 0, 1); step();
    chk_all("resume", 0, 32'h0, 32'h34, 32'h38, 0);
    drive(1, 0, 0, 0);
    for (int a = 'h38; a <= 'h40; a += 4) begin
      step();
      chk_all($sformatf("resume.run%0h", a), 1, 32'h0, 32'(a), 32'(a + 4), 0);
    end
    step();
    chk_all("resume.rehalt", 1, 32'h0, 32'h44, 32'h48, 1);

    // resume together with redirect: redirect target wins
    drive(1, 1, 32'h10, 1); step();
    chk_all("res_redir", 0, 32'h0, 32'h44, 32'h10, 0);
    drive(1, 0, 0, 0); step();
    chk_all("res_redir.after", 1, rom(32'h10), 32'h10, 32'h14, 0);

    // pc wrap at the top of the address space
    drive(1, 1, 32'hFFFF_FFFC, 0); step();
    chk("wrap.imem_addr0", imem_addr, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0); step();
    chk_all("wrap", 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 0);

    // async reset between edges while stalled
    step();
    chk_all("prerst", 1, rom(0), 32'h0, 32'h4, 0);
    drive(0, 0, 0, 0); step();
    #2 reset = 1'b1;
    #1;
    chk_all("rst_async", 0, 32'h0, 32'h0, 32'h0, 0);
    #1 reset = 1'b0;
    drive(1, 0, 0, 0);
    step();
    chk_all("rst.boot", 0, 32'h0, 32'h0, 32'h0, 0);
    step();
    chk_all("rst.first", 1, rom(0), 32'h0, 32'h4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
